mem_stage: RTL and testbench

- Pipeline stage directly downstream of execute. Consumes the execute-stage MEM_* outputs and registers results toward writeback as WB_*.
- Runs loads and stores against the data memory with a request/ready handshake, and stalls upstream while an access is outstanding.
- Formats load data and generates byte strobes for stores.
- Resolves branch, JAL and JALR redirects toward fetch.

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: data-memory access, load formatting, store strobes
// and fetch redirects, registered toward writeback.
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_V,
  input  logic [31:0]       MEM_IR,
  input  logic [XLEN-1:0]   MEM_RES,
  input  logic [XLEN-1:0]   MEM_Address,
  input  logic [XLEN-1:0]   MEM_NPC,
  input  logic [XLEN-1:0]   MEM_Target_Address,
  input  logic              MEM_PC_MUX,
  input  logic [3:0]        MEM_Cst,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN-1:0]   DMEM_WDATA,
  output logic [STRB_W-1:0] DMEM_WSTRB,
  input  logic              DMEM_READY,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  output logic              V_MEM_STALL,
  output logic              MEM_FE_BR_TAKEN,
  output logic [XLEN-1:0]   MEM_FE_TARGET,
  output logic              WB_V,
  output logic              WB_WE,
  output logic [4:0]        WB_DR,
  output logic [XLEN-1:0]   WB_RES,
  output logic [31:0]       WB_IR,
  output logic              WB_EXC
);

  localparam int OW = $clog2(STRB_W);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              br_q, br_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              wbv_q, wbv_d;
  logic              wbwe_q, wbwe_d;
  logic [4:0]        wbdr_q, wbdr_d;
  logic [XLEN-1:0]   wbres_q, wbres_d;
  logic [31:0]       wbir_q, wbir_d;
  logic              wbexc_q, wbexc_d;

  logic [4:0]        opc;
  logic [2:0]        size;
  logic [OW-1:0]     off;
  logic [4:0]        rd;
  logic              is_ld, is_st, is_br, is_jal, is_jalr;
  logic              is_mem, misal, go_mem, done;
  logic [XLEN-1:0]   lane, ld_val, st_data;
  logic [STRB_W-1:0] strb_base, st_strb;
  logic              unused_cst;

  assign opc     = MEM_IR[6:2];
  assign size    = MEM_IR[14:12];
  assign rd      = MEM_IR[11:7];
  assign off     = MEM_RES[OW-1:0];
  assign is_ld   = (opc == 5'b00000);
  assign is_st   = (opc == 5'b01000);
  assign is_br   = (opc == 5'b11000);
  assign is_jal  = (opc == 5'b11011);
  assign is_jalr = (opc == 5'b11001);
  assign is_mem  = is_ld | is_st;

  assign unused_cst = ^MEM_Cst;

  always_comb begin
    misal = 1'b0;
    unique case (size[1:0])
      2'b01:   misal = off[0];
      2'b10:   misal = |off[1:0];
      2'b11:   misal = |off;
      default: misal = 1'b0;
    endcase
  end

  assign go_mem      = MEM_V & is_mem & ~misal;
  assign done        = (state_q == ACCESS) & DMEM_READY;
  assign V_MEM_STALL = go_mem & ~done;

  // Loads pick their lane out of the aligned doubleword
  assign lane = DMEM_RDATA >> {off, 3'b000};

  always_comb begin
    ld_val = lane;
    unique case (size)
      3'b000:  ld_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ld_val = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  ld_val = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    strb_base = '1;
    unique case (size[1:0])
      2'b00:   strb_base = STRB_W'(8'h01);
      2'b01:   strb_base = STRB_W'(8'h03);
      2'b10:   strb_base = STRB_W'(8'h0F);
      default: strb_base = '1;
    endcase
  end

  assign st_strb = strb_base << off;
  assign st_data = MEM_Address << {off, 3'b000};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wbv_d   = 1'b0;
    wbwe_d  = 1'b0;
    wbexc_d = 1'b0;
    wbdr_d  = wbdr_q;
    wbres_d = wbres_q;
    wbir_d  = wbir_q;
    br_d    = MEM_V & ((is_br & MEM_PC_MUX) | is_jal | is_jalr);
    tgt_d   = MEM_Target_Address;
    unique case (state_q)
      IDLE: begin
        if (go_mem) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {MEM_RES[XLEN-1:OW], {OW{1'b0}}};
          wdata_d = is_st ? st_data : '0;
          wstrb_d = is_st ? st_strb : '0;
        end else begin
          wbv_d   = MEM_V;
          wbdr_d  = rd;
          wbir_d  = MEM_IR;
          wbres_d = (is_jal | is_jalr) ? MEM_NPC : MEM_RES;
          if (MEM_V & is_mem) begin
            wbexc_d = 1'b1;
            wbres_d = MEM_RES;
          end else begin
            wbwe_d = MEM_V & ~is_st & ~is_br & (rd != 5'd0);
          end
        end
      end
      ACCESS: begin
        if (DMEM_READY) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          wbdr_d  = rd;
          wbir_d  = MEM_IR;
          wbres_d = we_q ? MEM_RES : ld_val;
          wbwe_d  = ~we_q & (rd != 5'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
      wbv_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      wbdr_q  <= '0;
      wbres_q <= '0;
      wbir_q  <= '0;
      wbexc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
      wbv_q   <= wbv_d;
      wbwe_q  <= wbwe_d;
      wbdr_q  <= wbdr_d;
      wbres_q <= wbres_d;
      wbir_q  <= wbir_d;
      wbexc_q <= wbexc_d;
    end
  end

  assign DMEM_REQ        = req_q;
  assign DMEM_WE         = we_q;
  assign DMEM_ADDR       = addr_q;
  assign DMEM_WDATA      = wdata_q;
  assign DMEM_WSTRB      = wstrb_q;
  assign MEM_FE_BR_TAKEN = br_q;
  assign MEM_FE_TARGET   = tgt_q;
  assign WB_V            = wbv_q;
  assign WB_WE           = wbwe_q;
  assign WB_DR           = wbdr_q;
  assign WB_RES          = wbres_q;
  assign WB_IR           = wbir_q;
  assign WB_EXC          = wbexc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected writeback
// and redirect results; a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MEM_V = 1'b0;
  logic [31:0] MEM_IR = '0;
  logic [63:0] MEM_RES = '0;
  logic [63:0] MEM_Address = '0;
  logic [63:0] MEM_NPC = '0;
  logic [63:0] MEM_Target_Address = '0;
  logic        MEM_PC_MUX = 1'b0;
  logic [3:0]  MEM_Cst = '0;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_READY = 1'b0;
  logic [63:0] DMEM_RDATA = '0;
  logic        V_MEM_STALL, MEM_FE_BR_TAKEN;
  logic [63:0] MEM_FE_TARGET;
  logic        WB_V, WB_WE, WB_EXC;
  logic [4:0]  WB_DR;
  logic [63:0] WB_RES;
  logic [31:0] WB_IR;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
    .MEM_RES(MEM_RES), .MEM_Address(MEM_Address), .MEM_NPC(MEM_NPC),
    .MEM_Target_Address(MEM_Target_Address), .MEM_PC_MUX(MEM_PC_MUX),
    .MEM_Cst(MEM_Cst), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_READY(DMEM_READY),
    .DMEM_RDATA(DMEM_RDATA), .V_MEM_STALL(V_MEM_STALL),
    .MEM_FE_BR_TAKEN(MEM_FE_BR_TAKEN), .MEM_FE_TARGET(MEM_FE_TARGET),
    .WB_V(WB_V), .WB_WE(WB_WE), .WB_DR(WB_DR), .WB_RES(WB_RES),
    .WB_IR(WB_IR), .WB_EXC(WB_EXC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [4:0]  dr;
    logic [63:0] res;
    logic        exc;
    logic        chkres;
  } wb_t;

  wb_t         wbq[$];
  logic [63:0] brq[$];
  int          tests = 0;
  int          failed = 0;
  int          last_stalls;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  logic [63:0] snap_addr, snap_wdata;
  logic [7:0]  snap_wstrb;
  logic        snap_we;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'b0, f3, rd, op, 2'b11};
  endfunction

  task automatic push_wb(input logic we, input logic [4:0] dr,
                         input logic [63:0] res, input logic exc,
                         input logic chkres);
    wb_t e;
    e.we = we; e.dr = dr; e.res = res; e.exc = exc; e.chkres = chkres;
    wbq.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ir, input logic [63:0] res,
                       input logic [63:0] adr, input logic [63:0] npc,
                       input logic [63:0] tgt, input logic pcmux);
    MEM_V = 1'b1; MEM_IR = ir; MEM_RES = res; MEM_Address = adr;
    MEM_NPC = npc; MEM_Target_Address = tgt; MEM_PC_MUX = pcmux;
  endtask

  task automatic issue1();
    @(negedge CLK);
    chk("stall_nonmem", 64'(V_MEM_STALL), 64'd0);
    @(posedge CLK); #1;
    MEM_V = 1'b0;
  endtask

  task automatic take_snap();
    snap_addr = DMEM_ADDR; snap_wdata = DMEM_WDATA;
    snap_wstrb = DMEM_WSTRB; snap_we = DMEM_WE;
  endtask

  task automatic chk_hold();
    chk("hold_addr", DMEM_ADDR, snap_addr);
    chk("hold_wstrb", 64'(DMEM_WSTRB), 64'(snap_wstrb));
  endtask

  // Memory op already driven; READY comes after lat waiting cycles
  task automatic run_mem(input int lat, input logic [63:0] rdata);
    int stalls;
    stalls = 0;
    @(negedge CLK);
    stalls += int'(V_MEM_STALL);
    chk("req_gap", 64'(DMEM_REQ), 64'd0);
    for (int i = 0; i < lat; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      stalls += int'(V_MEM_STALL);
      if (i == 0) take_snap();
      else chk_hold();
    end
    @(posedge CLK); #1;
    DMEM_READY = 1'b1; DMEM_RDATA = rdata;
    @(negedge CLK);
    stalls += int'(V_MEM_STALL);
    if (lat == 0) take_snap();
    else chk_hold();
    chk("req_on", 64'(DMEM_REQ), 64'd1);
    @(posedge CLK); #1;
    DMEM_READY = 1'b0; DMEM_RDATA = '0; MEM_V = 1'b0;
    last_stalls = stalls;
  endtask

  always @(negedge CLK) begin
    if (DMEM_REQ && !req_prev) req_rises++;
    req_prev = DMEM_REQ;
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (WB_V) begin
        if (wbq.size() == 0) begin
          tests++; failed++;
          $display("FAIL wb_spurious: got res %h expected none", WB_RES);
        end else begin
          wb_t e;
          e = wbq.pop_front();
          chk("wb_we", 64'(WB_WE), 64'(e.we));
          chk("wb_dr", 64'(WB_DR), 64'(e.dr));
          chk("wb_exc", 64'(WB_EXC), 64'(e.exc));
          if (e.chkres) chk("wb_res", WB_RES, e.res);
        end
      end
      if (MEM_FE_BR_TAKEN) begin
        if (brq.size() == 0) begin
          tests++; failed++;
          $display("FAIL br_spurious: got %h expected none", MEM_FE_TARGET);
        end else begin
          chk("br_target", MEM_FE_TARGET, brq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_wbv", 64'(WB_V), 64'd0);
    chk("rst_br", 64'(MEM_FE_BR_TAKEN), 64'd0);
    chk("rst_wstrb", 64'(DMEM_WSTRB), 64'd0);
    chk("rst_wbres", WB_RES, 64'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;

    // ALU op, rd=5
    push_wb(1'b1, 5'd5, 64'h1234, 1'b0, 1'b1);
    drive(mk(5'b01100, 3'b000, 5'd5), 64'h1234, 0, 0, 0, 1'b0);
    issue1();

    // ALU op to x0: no register write
    push_wb(1'b0, 5'd0, 64'h55, 1'b0, 1'b1);
    drive(mk(5'b00100, 3'b000, 5'd0), 64'h55, 0, 0, 0, 1'b0);
    issue1();
    @(posedge CLK); #1;

    // LB at 0x1003, three wait cycles
    push_wb(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
    drive(mk(5'b00000, 3'b000, 5'd7), 64'h1003, 0, 0, 0, 1'b0);
    run_mem(3, 64'h0000_0000_8000_0000);
    chk("lb_stalls", 64'(last_stalls), 64'd4);
    chk("lb_addr", snap_addr, 64'h1000);
    chk("lb_we", 64'(snap_we), 64'd0);
    chk("lb_wstrb", 64'(snap_wstrb), 64'd0);

    // SH 0xABCD at 0x2006
    push_wb(1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    drive(mk(5'b01000, 3'b001, 5'd0), 64'h2006, 64'hABCD, 0, 0, 1'b0);
    run_mem(1, 64'h0);
    chk("sh_stalls", 64'(last_stalls), 64'd2);
    chk("sh_addr", snap_addr, 64'h2000);
    chk("sh_wstrb", 64'(snap_wstrb), 64'hC0);
    chk("sh_wdata", snap_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", 64'(snap_we), 64'd1);

    // SD, zero wait
    push_wb(1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    drive(mk(5'b01000, 3'b011, 5'd0), 64'h8000,
          64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
    run_mem(0, 64'h0);
    chk("sd_stalls", 64'(last_stalls), 64'd1);
    chk("sd_wstrb", 64'(snap_wstrb), 64'hFF);
    chk("sd_wdata", snap_wdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Misaligned LW at 0x3002
    push_wb(1'b0, 5'd9, 64'h3002, 1'b1, 1'b1);
    drive(mk(5'b00000, 3'b010, 5'd9), 64'h3002, 0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("mis_stall", 64'(V_MEM_STALL), 64'd0);
    chk("mis_req0", 64'(DMEM_REQ), 64'd0);
    @(posedge CLK); #1;
    MEM_V = 1'b0;
    @(negedge CLK);
    chk("mis_req1", 64'(DMEM_REQ), 64'd0);
    @(posedge CLK); #1;

    // LHU at 0x7002 and LW at 0x7004
    push_wb(1'b1, 5'd12, 64'hF00D, 1'b0, 1'b1);
    drive(mk(5'b00000, 3'b101, 5'd12), 64'h7002, 0, 0, 0, 1'b0);
    run_mem(1, 64'h0000_0000_F00D_0000);
    push_wb(1'b1, 5'd13, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1);
    drive(mk(5'b00000, 3'b010, 5'd13), 64'h7004, 0, 0, 0, 1'b0);
    run_mem(2, 64'h8000_0001_0000_0000);

    // Taken BEQ, not-taken BEQ, JAL
    brq.push_back(64'h400);
    push_wb(1'b0, 5'd0, 64'h1, 1'b0, 1'b1);
    drive(mk(5'b11000, 3'b000, 5'd0), 64'h1, 0, 64'h304, 64'h400, 1'b1);
    issue1();
    push_wb(1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
    drive(mk(5'b11000, 3'b000, 5'd0), 64'h0, 0, 64'h308, 64'h500, 1'b0);
    issue1();
    brq.push_back(64'h200);
    push_wb(1'b1, 5'd1, 64'h104, 1'b0, 1'b1);
    drive(mk(5'b11011, 3'b000, 5'd1), 64'h200, 0, 64'h104, 64'h200, 1'b0);
    issue1();
    repeat (2) @(posedge CLK); #1;

    // Reset in the middle of an access
    drive(mk(5'b00000, 3'b011, 5'd3), 64'h5000, 0, 0, 0, 1'b0);
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre_rst_req", 64'(DMEM_REQ), 64'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_mid_wbv", 64'(WB_V), 64'd0);
    chk("rst_mid_addr", DMEM_ADDR, 64'd0);
    MEM_V = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("no_retry", 64'(DMEM_REQ), 64'd0);
    @(posedge CLK); #1;

    // Back-to-back LDs
    req_rises = 0;
    push_wb(1'b1, 5'd10, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
    drive(mk(5'b00000, 3'b011, 5'd10), 64'h6008, 0, 0, 0, 1'b0);
    run_mem(1, 64'h1122_3344_5566_7788);
    push_wb(1'b1, 5'd11, 64'h8877_6655_4433_2211, 1'b0, 1'b1);
    drive(mk(5'b00000, 3'b011, 5'd11), 64'h6010, 0, 0, 0, 1'b0);
    run_mem(1, 64'h8877_6655_4433_2211);
    chk("b2b_addr", snap_addr, 64'h6010);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("b2b_reqs", 64'(req_rises), 64'd2);
    chk("wb_drain", 64'(wbq.size()), 64'd0);
    chk("br_drain", 64'(brq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
